// File: rtl/score_display_ctrl.sv
`timescale 1ns/1ps
// score_display_ctrl
//   Converts the binary game score into an N-digit BCD display value. It
//   follows the score one count per clock (multi-point catch-up), saturates
//   at all-9s with a sticky overflow flag, and clears when the score goes
//   backwards. On the pixel side it maps the beam position (X,Y) to a
//   glyph-ROM address, a BCD digit selector and a draw enable, with one
//   cycle of latency.
//
//   Optional feature macro: SCORE_LEADING_ZERO_BLANK_EN. When it is defined,
//   leading zero digits are not drawn. The least significant digit is always
//   drawn.
//
// Ports
//   clock_25              in   25 MHz pixel clock
//   reset                 in   asynchronous active-high reset
//   sync_reset            in   synchronous clear (new game), highest priority
//   score                 in   binary score from the game logic
//   X, Y                  in   current beam column / row
//   selected_score_number out  BCD digit under the beam (ROM bank select)
//   score_count           out  glyph-ROM address = row*GLYPH_W + col
//   en_score              out  pixel lies inside a drawn glyph
//   bcd_value             out  displayed value, most significant digit on top
//   busy                  out  counter is catching up (INC or CLEAR)
//   overflow              out  sticky: score exceeded the display range
module score_display_ctrl #(
  parameter int PIXEL_DISPLAY_BIT = 9,
  parameter int SCORE_W           = 10,
  parameter int NUM_DIGITS        = 3,
  parameter int ORIGIN_X          = 440,
  parameter int ORIGIN_Y          = 466,
  parameter int GLYPH_W           = 10,
  parameter int GLYPH_H           = 10,
  parameter int DIGIT_PITCH       = 15,
  parameter int ROM_ADDR_W        = 8
) (
  input  logic                        clock_25,
  input  logic                        reset,
  input  logic                        sync_reset,
  input  logic [SCORE_W-1:0]          score,
  input  logic [PIXEL_DISPLAY_BIT:0]  X,
  input  logic [PIXEL_DISPLAY_BIT:0]  Y,
  output logic [3:0]                  selected_score_number,
  output logic [ROM_ADDR_W-1:0]       score_count,
  output logic                        en_score,
  output logic [4*NUM_DIGITS-1:0]     bcd_value,
  output logic                        busy,
  output logic                        overflow
);

  localparam int PW = PIXEL_DISPLAY_BIT + 1;
  localparam int BW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] OX = PW'(ORIGIN_X);
  localparam logic [PW-1:0] OY = PW'(ORIGIN_Y);
  localparam logic [PW-1:0] GW = PW'(GLYPH_W);
  localparam logic [PW-1:0] GH = PW'(GLYPH_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INC   = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Rippling BCD increment. The top bit of the result flags a carry out of the
  // most significant nibble; in that case the value is returned unchanged,
  // which gives saturation at all-9s.
  function automatic logic [BW:0] bcd_inc(input logic [BW-1:0] v);
    logic [BW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
          carry       = 1'b1;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end else begin
        r[i*4 +: 4] = v[i*4 +: 4];
      end
    end
    if (carry) begin
      return {1'b1, v};
    end else begin
      return {1'b0, r};
    end
  endfunction

  state_t                state_q, state_d;
  logic [SCORE_W-1:0]    prev_q, prev_d, prev_p1_s;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic [BW:0]           inc_s;
  logic                  ovf_q, ovf_d;
  logic                  busy_q, busy_d;

  // Counter FSM: next state, next count and overflow.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    prev_p1_s = prev_q + {{(SCORE_W-1){1'b0}}, 1'b1};
    inc_s     = bcd_inc(bcd_q);
    case (state_q)
      IDLE: begin
        if (score > prev_q) begin
          state_d = INC;
        end else if (score < prev_q) begin
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      INC: begin
        if (score < prev_p1_s) begin
          // Score went backwards while catching up: restart from zero.
          state_d = CLEAR;
        end else begin
          prev_d = prev_p1_s;
          bcd_d  = inc_s[BW-1:0];
          if (inc_s[BW]) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          if (score == prev_p1_s) begin
            state_d = IDLE;
          end else begin
            state_d = INC;
          end
        end
      end
      CLEAR: begin
        bcd_d   = {BW{1'b0}};
        prev_d  = {SCORE_W{1'b0}};
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Counter state registers.
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= {SCORE_W{1'b0}};
      bcd_q   <= {BW{1'b0}};
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else if (sync_reset) begin
      state_q <= IDLE;
      prev_q  <= {SCORE_W{1'b0}};
      bcd_q   <= {BW{1'b0}};
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
    end
  end

  assign bcd_value = bcd_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

  // ---------------------------------------------------------------- pixels
  logic [PW-1:0]         row_s, dx_s, col_s;
  logic                  in_y_s, in_x_s;
  logic                  en_d, en_q;
  logic [ROM_ADDR_W-1:0] addr_d, addr_q;
  logic [3:0]            sel_d, sel_q;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
  logic                  zero_run_s;
`endif

  // Beam-to-glyph mapping: one window compare per digit instead of a divide.
  always_comb begin
    row_s  = Y - OY;
    dx_s   = X - OX;
    col_s  = {PW{1'b0}};
    in_y_s = (Y >= OY) && (Y < OY + GH);
    in_x_s = (X >= OX);
    en_d   = 1'b0;
    addr_d = {ROM_ADDR_W{1'b0}};
    sel_d  = 4'd0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    zero_run_s = 1'b1;
`endif
    for (int d = 0; d < NUM_DIGITS; d++) begin
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      // True while this digit and every digit to its left are zero.
      zero_run_s = zero_run_s && (bcd_q[(NUM_DIGITS-1-d)*4 +: 4] == 4'd0);
`endif
      if (in_y_s && in_x_s &&
          (dx_s >= PW'(d * DIGIT_PITCH)) &&
          (dx_s <  PW'(d * DIGIT_PITCH + GLYPH_W))) begin
        col_s  = dx_s - PW'(d * DIGIT_PITCH);
        addr_d = ROM_ADDR_W'(row_s * GW + col_s);
        sel_d  = bcd_q[(NUM_DIGITS-1-d)*4 +: 4];
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        en_d   = !(zero_run_s && (d != NUM_DIGITS - 1));
`else
        en_d   = 1'b1;
`endif
      end else begin
        col_s = col_s;
      end
    end
  end

  // Pixel output registers (one cycle after X,Y).
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      en_q   <= 1'b0;
      addr_q <= {ROM_ADDR_W{1'b0}};
      sel_q  <= 4'd0;
    end else if (sync_reset) begin
      en_q   <= 1'b0;
      addr_q <= {ROM_ADDR_W{1'b0}};
      sel_q  <= 4'd0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      sel_q  <= sel_d;
    end
  end

  assign en_score              = en_q;
  assign score_count           = addr_q;
  assign selected_score_number = sel_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
`timescale 1ns/1ps
module tb_score_display_ctrl;

  logic        clock_25 = 1'b0;
  logic        reset;
  logic        sync_reset;
  logic [9:0]  score;
  logic [9:0]  X;
  logic [9:0]  Y;
  logic [3:0]  selected_score_number;
  logic [7:0]  score_count;
  logic        en_score;
  logic [11:0] bcd_value;
  logic        busy;
  logic        overflow;

  score_display_ctrl dut (
    .clock_25              (clock_25),
    .reset                 (reset),
    .sync_reset            (sync_reset),
    .score                 (score),
    .X                     (X),
    .Y                     (Y),
    .selected_score_number (selected_score_number),
    .score_count           (score_count),
    .en_score              (en_score),
    .bcd_value             (bcd_value),
    .busy                  (busy),
    .overflow              (overflow)
  );

  always #20 clock_25 = ~clock_25;

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam logic BLANK = 1'b1;
`else
  localparam logic BLANK = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
    logic [7:0] addr;
    logic [3:0] sel;
  } pix_vec_t;

  typedef struct {
    logic       en;
    logic [7:0] addr;
    logic [3:0] sel;
  } pix_exp_t;

  pix_exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive X,Y, queue the expectation, compare one cycle later.
  task automatic apply_pix(input pix_vec_t v, input int idx);
    pix_exp_t e;
    @(negedge clock_25);
    X = v.x;
    Y = v.y;
    sb_q.push_back('{v.en, v.addr, v.sel});
    @(posedge clock_25);
    #1;
    e = sb_q.pop_front();
    check($sformatf("pix%0d en", idx),   {31'd0, en_score}, {31'd0, e.en});
    check($sformatf("pix%0d addr", idx), {24'd0, score_count}, {24'd0, e.addr});
    check($sformatf("pix%0d sel", idx),  {28'd0, selected_score_number}, {28'd0, e.sel});
  endtask

  // Count busy cycles of one catch-up burst.
  task automatic run_count(input int bound, input string name, output int cnt);
    logic started;
    started = 1'b0;
    cnt     = 0;
    for (int i = 0; i < bound; i++) begin
      @(posedge clock_25);
      #1;
      if (busy) begin
        started = 1'b1;
        cnt++;
      end else if (started) begin
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL %s timeout: got busy count %0d after %0d cycles", name, cnt, bound);
  endtask

  task automatic wait_idle(input logic [11:0] exp_bcd, input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(posedge clock_25);
      #1;
      if (!busy && bcd_value == exp_bcd) return;
    end
    total++;
    bad++;
    $display("FAIL %s timeout: got bcd %0h expected %0h", name, bcd_value, exp_bcd);
  endtask

  pix_vec_t tbl42[12];
  pix_vec_t tbl7[3];
  int       cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // bcd_value = 0x042: digit0 = 0 (X 440..449), digit1 = 4 (455..464), digit2 = 2 (470..479)
    tbl42[0]  = '{10'd458, 10'd468, 1'b1,   8'd23, 4'd4};
    tbl42[1]  = '{10'd466, 10'd468, 1'b0,   8'd0,  4'd0};
    tbl42[2]  = '{10'd440, 10'd466, ~BLANK, 8'd0,  4'd0};
    tbl42[3]  = '{10'd449, 10'd475, ~BLANK, 8'd99, 4'd0};
    tbl42[4]  = '{10'd479, 10'd475, 1'b1,   8'd99, 4'd2};
    tbl42[5]  = '{10'd480, 10'd470, 1'b0,   8'd0,  4'd0};
    tbl42[6]  = '{10'd439, 10'd470, 1'b0,   8'd0,  4'd0};
    tbl42[7]  = '{10'd470, 10'd465, 1'b0,   8'd0,  4'd0};
    tbl42[8]  = '{10'd470, 10'd476, 1'b0,   8'd0,  4'd0};
    tbl42[9]  = '{10'd470, 10'd466, 1'b1,   8'd0,  4'd2};
    tbl42[10] = '{10'd455, 10'd471, 1'b1,   8'd50, 4'd4};
    tbl42[11] = '{10'd454, 10'd471, 1'b0,   8'd0,  4'd0};
    // bcd_value = 0x007, row 4, col 3 of every digit
    tbl7[0]   = '{10'd443, 10'd470, ~BLANK, 8'd43, 4'd0};
    tbl7[1]   = '{10'd458, 10'd470, ~BLANK, 8'd43, 4'd0};
    tbl7[2]   = '{10'd473, 10'd470, 1'b1,   8'd43, 4'd7};

    reset      = 1'b1;
    sync_reset = 1'b0;
    score      = 10'd0;
    X          = 10'd458;
    Y          = 10'd468;
    repeat (3) @(posedge clock_25);
    #1;
    check("rst bcd",  {20'd0, bcd_value}, 32'h0);
    check("rst busy", {31'd0, busy}, 32'h0);
    check("rst ovf",  {31'd0, overflow}, 32'h0);
    check("rst en",   {31'd0, en_score}, 32'h0);
    check("rst addr", {24'd0, score_count}, 32'h0);
    check("rst sel",  {28'd0, selected_score_number}, 32'h0);
    @(negedge clock_25);
    reset = 1'b0;

    // 0 -> 7
    @(negedge clock_25);
    score = 10'd7;
    run_count(50, "inc7", cnt);
    check("inc7 cycles", cnt, 32'd7);
    check("inc7 bcd", {20'd0, bcd_value}, 32'h007);

    // 7 -> 12
    @(negedge clock_25);
    score = 10'd12;
    run_count(50, "inc12", cnt);
    check("inc12 cycles", cnt, 32'd5);
    check("inc12 bcd", {20'd0, bcd_value}, 32'h012);

    // async reset in the middle of a catch-up toward 50
    @(negedge clock_25);
    score = 10'd50;
    repeat (10) @(posedge clock_25);
    #5;
    reset = 1'b1;
    #1;
    check("midrst bcd",  {20'd0, bcd_value}, 32'h0);
    check("midrst busy", {31'd0, busy}, 32'h0);
    check("midrst en",   {31'd0, en_score}, 32'h0);
    check("midrst addr", {24'd0, score_count}, 32'h0);
    @(negedge clock_25);
    reset = 1'b0;
    run_count(80, "recount50", cnt);
    check("recount50 cycles", cnt, 32'd50);
    check("recount50 bcd", {20'd0, bcd_value}, 32'h050);

    // 50 -> 120, then drop to 30
    @(negedge clock_25);
    score = 10'd120;
    run_count(100, "inc120", cnt);
    check("inc120 cycles", cnt, 32'd70);
    check("inc120 bcd", {20'd0, bcd_value}, 32'h120);
    @(negedge clock_25);
    score = 10'd30;
    @(posedge clock_25);
    #1;
    check("clear busy", {31'd0, busy}, 32'h1);
    @(posedge clock_25);
    #1;
    check("clear bcd", {20'd0, bcd_value}, 32'h000);
    check("clear idle", {31'd0, busy}, 32'h0);
    run_count(60, "inc30", cnt);
    check("inc30 cycles", cnt, 32'd30);
    check("inc30 bcd", {20'd0, bcd_value}, 32'h030);

    // pixel path at 0x042
    @(negedge clock_25);
    score = 10'd42;
    wait_idle(12'h042, 40, "settle42");
    for (int i = 0; i < 12; i++) apply_pix(tbl42[i], i);

    // pixel path at 0x007 (leading zeros)
    @(negedge clock_25);
    score = 10'd7;
    wait_idle(12'h007, 40, "settle7");
    for (int i = 0; i < 3; i++) apply_pix(tbl7[i], 100 + i);

    // saturation
    @(negedge clock_25);
    score = 10'd998;
    wait_idle(12'h998, 1100, "settle998");
    check("pre-sat ovf", {31'd0, overflow}, 32'h0);
    @(negedge clock_25);
    score = 10'd1005;
    run_count(50, "sat", cnt);
    check("sat cycles", cnt, 32'd7);
    check("sat bcd", {20'd0, bcd_value}, 32'h999);
    check("sat ovf", {31'd0, overflow}, 32'h1);
    @(posedge clock_25);
    #1;
    check("sat ovf sticky", {31'd0, overflow}, 32'h1);

    // sync_reset clears overflow and count
    @(negedge clock_25);
    sync_reset = 1'b1;
    @(posedge clock_25);
    #1;
    check("srst bcd",  {20'd0, bcd_value}, 32'h000);
    check("srst ovf",  {31'd0, overflow}, 32'h0);
    check("srst busy", {31'd0, busy}, 32'h0);
    @(negedge clock_25);
    sync_reset = 1'b0;
    score      = 10'd0;
    repeat (3) @(posedge clock_25);
    #1;
    check("post-srst bcd", {20'd0, bcd_value}, 32'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
